// File: rtl/kgp_alu_mc_pkg.sv
// Shared definitions for the KGP multi-cycle ALU: op codes, flag bit
// positions and FSM state encodings.
package kgp_alu_mc_pkg;

    // Operation codes; 4'hC..4'hF are unassigned (illegal).
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_COMP  = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_XOR   = 4'h3;
    localparam logic [3:0] OP_SLL   = 4'h4;
    localparam logic [3:0] OP_SRL   = 4'h5;
    localparam logic [3:0] OP_SRA   = 4'h6;
    localparam logic [3:0] OP_SLLV  = 4'h7;
    localparam logic [3:0] OP_SRLV  = 4'h8;
    localparam logic [3:0] OP_SRAV  = 4'h9;
    localparam logic [3:0] OP_MUL   = 4'hA;
    localparam logic [3:0] OP_MULHU = 4'hB;

    // Flag vector layout {carry, zero, sign}.
    localparam int unsigned FLAGS_W = 3;
    localparam int unsigned FLAG_C  = 2;
    localparam int unsigned FLAG_Z  = 1;
    localparam int unsigned FLAG_S  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // True for the ops that run on the iterative multiplier.
    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/kgp_alu_mc_mul_iter.sv
// kgp_mul_iter: iterative unsigned shift-add multiplier, MUL_BPC multiplier
// bits retired per cycle, full 2*WIDTH product.
// Ports:
//   clk, rst      clock, async active-low reset (discards any run in flight)
//   start         load operands and perform the first step (only when idle)
//   a, b          multiplicand / multiplier, sampled on start
//   done_c        product complete this cycle (combinational)
//   product       2*WIDTH product register
module kgp_mul_iter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_BPC = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   done_c,
    output logic [2*WIDTH-1:0]     product
);

    localparam int unsigned K  = WIDTH / MUL_BPC;
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = WIDTH + MUL_BPC;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [PW-1:0]    step_src;
    logic [WIDTH-1:0] step_mc;
    logic [AW-1:0]    partial;
    logic [AW-1:0]    hi_sum;
    logic [PW-1:0]    prod_step;

    // One shift-add step. The low half holds the unconsumed multiplier bits;
    // product bits shift in from the top as they are consumed. The first step
    // runs at start so the whole multiply takes exactly K cycles.
    always_comb begin
        step_src  = start ? {WIDTH'(0), b} : prod_q;
        step_mc   = start ? a : mcand_q;
        partial   = AW'(step_mc) * AW'(step_src[MUL_BPC-1:0]);
        hi_sum    = AW'(step_src[PW-1:WIDTH]) + partial;
        prod_step = {hi_sum, step_src[WIDTH-1:MUL_BPC]};
    end

    // Iteration control: K-1 further steps after start, then one done cycle.
    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (start && !busy_q) begin
            mcand_d = a;
            prod_d  = prod_step;
            cnt_d   = CW'(K - 1);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                prod_d = prod_step;
                cnt_d  = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign done_c  = busy_q && (cnt_q == '0);
    assign product = prod_q;

endmodule

// File: rtl/kgp_alu_mc.sv
// kgp_alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops are registered at accept; MUL/MULHU use kgp_mul_iter.
// Ports:
//   clk, rst              clock, async active-low reset
//   in_valid/in_ready     operand handshake (ready only when idle)
//   op, a, b, shamt       operation, operands, immediate shift amount
//   out_valid/out_ready   result handshake
//   result, flags         registered result and {carry, zero, sign}
//   illegal               op code was unassigned
module kgp_alu_mc
    import kgp_alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_BPC = 1,
    parameter int unsigned SHW     = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHW-1:0]     shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [FLAGS_W-1:0] flags,
    output logic               illegal
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [FLAGS_W-1:0]   flags_q, flags_d;
    logic                 illegal_q, illegal_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 mulhu_q, mulhu_d;

    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_illegal;
    logic [WIDTH-1:0]     not_b;
    logic [SHW-1:0]       sh_var;
    logic                 mul_start;
    logic                 mul_done_c;
    logic [2*WIDTH-1:0]   mul_product;
    logic [WIDTH-1:0]     mul_res;

    kgp_mul_iter #(
        .WIDTH   (WIDTH),
        .MUL_BPC (MUL_BPC)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done_c  (mul_done_c),
        .product (mul_product)
    );

    // Single-cycle datapath; MUL/MULHU leave it at its defaults.
    always_comb begin
        alu_res     = '0;
        alu_c       = 1'b0;
        alu_illegal = 1'b0;
        not_b       = ~b;
        sh_var      = b[SHW-1:0];
        case (op)
            OP_ADD:   {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
            OP_COMP:  {alu_c, alu_res} = {1'b0, not_b} + (WIDTH+1)'(1);
            OP_AND:   alu_res = a & b;
            OP_XOR:   alu_res = a ^ b;
            OP_SLL:   alu_res = a << shamt;
            OP_SRL:   alu_res = a >> shamt;
            OP_SRA:   alu_res = WIDTH'($signed(a) >>> shamt);
            OP_SLLV:  alu_res = a << sh_var;
            OP_SRLV:  alu_res = a >> sh_var;
            OP_SRAV:  alu_res = WIDTH'($signed(a) >>> sh_var);
            OP_MUL,
            OP_MULHU: alu_res = '0;
            default:  alu_illegal = 1'b1;
        endcase
    end

    assign mul_res = mulhu_q ? mul_product[2*WIDTH-1:WIDTH] : mul_product[WIDTH-1:0];

    // FSM next state and output-register next values.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        mulhu_d   = mulhu_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_mul_op(op)) begin
                        mul_start = 1'b1;
                        mulhu_d   = (op == OP_MULHU);
                        state_d   = ST_MUL;
                    end else begin
                        result_d  = alu_res;
                        illegal_d = alu_illegal;
                        // Illegal ops report all-zero flags, not zero=1.
                        flags_d   = '0;
                        if (!alu_illegal) begin
                            flags_d[FLAG_C] = alu_c;
                            flags_d[FLAG_Z] = (alu_res == '0);
                            flags_d[FLAG_S] = alu_res[WIDTH-1];
                        end
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done_c) begin
                    result_d        = mul_res;
                    illegal_d       = 1'b0;
                    flags_d         = '0;
                    flags_d[FLAG_Z] = (mul_res == '0);
                    flags_d[FLAG_S] = mul_res[WIDTH-1];
                    state_d         = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mulhu_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            illegal_q   <= illegal_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            mulhu_q     <= mulhu_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_kgp_alu_mc.sv
// Bench for kgp_alu_mc: directed cases plus random ops against a reference
// model, on two instances (MUL_BPC=1 and MUL_BPC=4) sharing operand inputs.
module tb_kgp_alu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid1 = 1'b0;
    logic        in_valid4 = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  shamt = '0;
    logic        out_ready = 1'b0;

    logic        in_ready1, out_valid1, illegal1;
    logic [31:0] result1;
    logic [2:0]  flags1;
    logic        in_ready4, out_valid4, illegal4;
    logic [31:0] result4;
    logic [2:0]  flags4;

    int n_checks = 0;
    int n_fail   = 0;
    bit sel      = 1'b0;

    always #5 clk = ~clk;

    kgp_alu_mc #(.WIDTH(32), .MUL_BPC(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .op(op), .a(a), .b(b), .shamt(shamt),
        .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .flags(flags1), .illegal(illegal1)
    );

    kgp_alu_mc #(.WIDTH(32), .MUL_BPC(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .op(op), .a(a), .b(b), .shamt(shamt),
        .out_valid(out_valid4), .out_ready(out_ready),
        .result(result4), .flags(flags4), .illegal(illegal4)
    );

    logic        s_in_ready, s_out_valid, s_illegal;
    logic [31:0] s_result;
    logic [2:0]  s_flags;
    always_comb begin
        s_in_ready  = sel ? in_ready4  : in_ready1;
        s_out_valid = sel ? out_valid4 : out_valid1;
        s_illegal   = sel ? illegal4   : illegal1;
        s_result    = sel ? result4    : result1;
        s_flags     = sel ? flags4     : flags1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: {illegal, carry, zero, sign, result}.
    function automatic logic [35:0] model(input logic [3:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [4:0] s);
        logic [32:0] sum;
        logic [63:0] p;
        logic [31:0] r;
        logic        c, ill;
        r = '0; c = 1'b0; ill = 1'b0;
        p = 64'(x) * 64'(y);
        case (o)
            4'd0:  begin sum = {1'b0, x} + {1'b0, y}; r = sum[31:0]; c = sum[32]; end
            4'd1:  begin r = 32'd0 - y; c = (y == 32'd0); end
            4'd2:  r = x & y;
            4'd3:  r = x ^ y;
            4'd4:  r = x << s;
            4'd5:  r = x >> s;
            4'd6:  r = 32'($signed(x) >>> s);
            4'd7:  r = x << y[4:0];
            4'd8:  r = x >> y[4:0];
            4'd9:  r = 32'($signed(x) >>> y[4:0]);
            4'd10: r = p[31:0];
            4'd11: r = p[63:32];
            default: ill = 1'b1;
        endcase
        if (ill) return {1'b1, 3'b000, 32'd0};
        return {1'b0, c, (r == 32'd0), r[31], r};
    endfunction

    task automatic set_valid(input bit v);
        if (sel) in_valid4 = v; else in_valid1 = v;
    endtask

    // Issue one op on the selected instance, check latency and result, drain it.
    task automatic do_op(input bit which, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] s, input string tag);
        logic [35:0] e;
        int lat, exp_lat, w;
        sel = which;
        e = model(o, x, y, s);
        exp_lat = (o == 4'd10 || o == 4'd11) ? (which ? 9 : 33) : 1;
        @(negedge clk);
        w = 0;
        while (!s_in_ready && w < 100) begin @(negedge clk); w++; end
        chk({tag, "_in_ready"}, 64'(s_in_ready), 64'(1));
        op = o; a = x; b = y; shamt = s;
        set_valid(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_valid(1'b0);
        a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
        lat = 1;
        while (!s_out_valid && lat < 100) begin @(negedge clk); lat++; end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_result"}, 64'(s_result), 64'(e[31:0]));
        chk({tag, "_flags"}, 64'(s_flags), 64'(e[34:32]));
        chk({tag, "_illegal"}, 64'(s_illegal), 64'(e[35]));
        chk({tag, "_busy"}, 64'(s_in_ready), 64'(0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drained"}, 64'({s_out_valid, s_in_ready}), 64'(2'b01));
    endtask

    initial begin
        int seen;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'({out_valid1, out_valid4}), 64'(0));
        chk("rst_result", 64'({result1, result4}), 64'(0));
        chk("rst_flags_illegal", 64'({flags1, illegal1, flags4, illegal4}), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'({in_ready1, in_ready4}), 64'(2'b11));

        // Directed cases
        do_op(0, 4'd0,  32'hFFFF_FFFF, 32'h1, 5'd0, "add_wrap");
        do_op(0, 4'd6,  32'h8000_0000, 32'h0, 5'd4, "sra");
        do_op(0, 4'd8,  32'h8000_0000, 32'h4, 5'd0, "srlv");
        do_op(0, 4'd10, 32'h0001_0001, 32'h0001_0001, 5'd0, "mul_bpc1");
        do_op(0, 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, "mulhu_bpc1");
        do_op(1, 4'd10, 32'h0001_0001, 32'h0001_0001, 5'd0, "mul_bpc4");
        do_op(1, 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, "mulhu_bpc4");
        do_op(0, 4'd15, 32'h0000_FFFF, 32'h0000_FFFF, 5'd0, "illegal");
        do_op(0, 4'd2,  32'h0000_F0F0, 32'h0000_FF00, 5'd0, "and_after_ill");
        do_op(0, 4'd4,  32'h1234_5678, 32'h0, 5'd0, "sll_zero");
        do_op(0, 4'd9,  32'h8765_4321, 32'h1F, 5'd0, "srav_max");

        // Backpressure: result held, new ops ignored
        sel = 1'b0;
        @(negedge clk);
        op = 4'd0; a = 32'd5; b = 32'd7; in_valid1 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 9)); a = $urandom; b = $urandom;
            chk("bp_hold", 64'({out_valid1, in_ready1, flags1, result1}),
                {28'd0, 1'b1, 1'b0, 3'b000, 32'd12});
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid1 = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release", 64'({out_valid1, in_ready1}), 64'(2'b01));
        @(negedge clk);
        chk("bp_no_extra", 64'({out_valid1, in_ready1}), 64'(2'b01));

        // Reset mid-multiply
        @(negedge clk);
        op = 4'd10; a = $urandom; b = $urandom; in_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midmul_rst_outs", 64'({out_valid1, flags1, illegal1, result1}), 64'(0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midmul_release", 64'({out_valid1, in_ready1}), 64'(2'b01));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid1) seen++;
        end
        chk("midmul_discarded", 64'(seen), 64'(0));
        do_op(0, 4'd1, 32'h0, 32'h0, 5'd0, "comp_zero");

        // Random ops against the model
        for (int i = 0; i < 30; i++) begin
            do_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  $urandom, $urandom, 5'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
